// File: rtl/csr_trap_sequencer_pkg.sv
// System/CSR definitions shared by the trap-entry sequencer and its bench.
package csr_trap_sequencer_pkg;

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam int MSTATUS_MIE    = 3;
   localparam int MSTATUS_MPIE   = 7;
   localparam int MSTATUS_MPP_HI = 12;
   localparam int MSTATUS_MPP_LO = 11;

   localparam logic [5:0] EXC_ECALL_M    = 6'hb;
   localparam logic [5:0] EXC_BREAKPOINT = 6'h3;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_W_MEPC    = 3'd1,
      ST_W_MCAUSE  = 3'd2,
      ST_W_MSTATUS = 3'd3,
      ST_REDIRECT  = 3'd4
   } trap_state_e;

endpackage

// File: rtl/csr_trap_sequencer_if.sv
// System-stage / CSR-file signal bundle around the trap sequencer.
interface csr_trap_sequencer_if #(
   parameter int XLEN   = 64,
   parameter int CSR_AW = 12
);
   logic              io_valid;
   logic              io_is_except;
   logic [5:0]        io_exception;
   logic [XLEN-1:0]   io_pc;
   logic [XLEN-1:0]   io_mstatus;
   logic [XLEN-1:0]   io_mtvec;
   logic              io_exu_csr_is_w;
   logic [CSR_AW-1:0] io_exu_csr_addr;
   logic [XLEN-1:0]   io_exu_csr_data;
   logic              io_ready;
   logic              io_busy;
   logic              io_flush;
   logic              io_csr_wen;
   logic [CSR_AW-1:0] io_csr_waddr;
   logic [XLEN-1:0]   io_csr_wdata;
   logic              io_redirect_valid;
   logic [XLEN-1:0]   io_redirect_pc;

   modport master (
      output io_valid, io_is_except, io_exception, io_pc, io_mstatus, io_mtvec,
             io_exu_csr_is_w, io_exu_csr_addr, io_exu_csr_data,
      input  io_ready, io_busy, io_flush, io_csr_wen, io_csr_waddr, io_csr_wdata,
             io_redirect_valid, io_redirect_pc
   );

   modport slave (
      input  io_valid, io_is_except, io_exception, io_pc, io_mstatus, io_mtvec,
             io_exu_csr_is_w, io_exu_csr_addr, io_exu_csr_data,
      output io_ready, io_busy, io_flush, io_csr_wen, io_csr_waddr, io_csr_wdata,
             io_redirect_valid, io_redirect_pc
   );
endinterface

// File: rtl/csr_wport_mux.sv
// CSR write-port arbiter: sequencer owns the port while busy, else EXU pass-through.
module csr_wport_mux #(
   parameter int XLEN   = 64,
   parameter int CSR_AW = 12
) (
   input  logic              i_en,
   input  logic              i_seq_sel,
   input  logic              i_drop_exu,
   input  logic              i_exu_wen,
   input  logic [CSR_AW-1:0] i_exu_addr,
   input  logic [XLEN-1:0]   i_exu_data,
   input  logic              i_seq_wen,
   input  logic [CSR_AW-1:0] i_seq_addr,
   input  logic [XLEN-1:0]   i_seq_data,
   output logic              o_wen,
   output logic [CSR_AW-1:0] o_addr,
   output logic [XLEN-1:0]   o_data
);

   always_comb begin
      o_wen  = 1'b0;
      o_addr = '0;
      o_data = '0;
      if (i_en) begin
         if (i_seq_sel) begin
            o_wen  = i_seq_wen;
            o_addr = i_seq_addr;
            o_data = i_seq_data;
         end else begin
            // an accepted trap wins the port; the EXU write is lost
            o_wen  = i_exu_wen & ~i_drop_exu;
            o_addr = i_exu_addr;
            o_data = i_exu_data;
         end
      end
   end

endmodule

// File: rtl/csr_trap_sequencer.sv
// Trap-entry controller: writes mepc, mcause, mstatus through the CSR port, then redirects to mtvec.
//
// state        | meaning
// ST_IDLE      | ready; EXU CSR writes pass through; accepts a trap
// ST_W_MEPC    | write mepc = snapshot pc, word aligned
// ST_W_MCAUSE  | write mcause = snapshot exception code
// ST_W_MSTATUS | write mstatus with MPIE<=MIE, MIE<=0, MPP<=M
// ST_REDIRECT  | pulse redirect to snapshot mtvec (direct mode)
module csr_trap_sequencer
   import csr_trap_sequencer_pkg::*;
#(
   parameter int XLEN   = 64,
   parameter int CSR_AW = 12
) (
   input logic                 clock,
   input logic                 reset,
   csr_trap_sequencer_if.slave bus
);

   trap_state_e       r_state;
   trap_state_e       w_state_nxt;
   logic [XLEN-1:0]   r_snap_pc;
   logic [5:0]        r_snap_code;
   logic [XLEN-1:0]   r_snap_mstatus;
   logic [XLEN-1:0]   r_snap_mtvec;

   logic              w_accept;
   logic              w_seq_wen;
   logic [CSR_AW-1:0] w_seq_addr;
   logic [XLEN-1:0]   w_seq_data;
   logic              w_redirect;
   logic [XLEN-1:0]   w_mstatus_upd;
   logic [XLEN-1:0]   w_align_mask;

   assign w_align_mask = ~XLEN'(3);
   assign w_accept     = (r_state == ST_IDLE) & bus.io_valid & bus.io_is_except;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state        <= ST_IDLE;
         r_snap_pc      <= '0;
         r_snap_code    <= '0;
         r_snap_mstatus <= '0;
         r_snap_mtvec   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_snap_pc      <= bus.io_pc;
            r_snap_code    <= bus.io_exception;
            r_snap_mstatus <= bus.io_mstatus;
            r_snap_mtvec   <= bus.io_mtvec;
         end
      end
   end

   always_comb begin
      w_mstatus_upd                               = r_snap_mstatus;
      w_mstatus_upd[MSTATUS_MPIE]                 = r_snap_mstatus[MSTATUS_MIE];
      w_mstatus_upd[MSTATUS_MIE]                  = 1'b0;
      w_mstatus_upd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_seq_wen   = 1'b0;
      w_seq_addr  = '0;
      w_seq_data  = '0;
      w_redirect  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) w_state_nxt = ST_W_MEPC;
         end
         ST_W_MEPC: begin
            w_seq_wen   = 1'b1;
            w_seq_addr  = CSR_AW'(CSR_MEPC);
            w_seq_data  = r_snap_pc & w_align_mask;
            w_state_nxt = ST_W_MCAUSE;
         end
         ST_W_MCAUSE: begin
            w_seq_wen   = 1'b1;
            w_seq_addr  = CSR_AW'(CSR_MCAUSE);
            w_seq_data  = XLEN'(r_snap_code);
            w_state_nxt = ST_W_MSTATUS;
         end
         ST_W_MSTATUS: begin
            w_seq_wen   = 1'b1;
            w_seq_addr  = CSR_AW'(CSR_MSTATUS);
            w_seq_data  = w_mstatus_upd;
            w_state_nxt = ST_REDIRECT;
         end
         ST_REDIRECT: begin
            w_redirect  = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.io_ready          = (r_state == ST_IDLE);
   assign bus.io_busy           = (r_state != ST_IDLE);
   assign bus.io_flush          = w_accept & reset;
   assign bus.io_redirect_valid = w_redirect;
   assign bus.io_redirect_pc    = w_redirect ? (r_snap_mtvec & w_align_mask) : '0;

   csr_wport_mux #(
      .XLEN   (XLEN),
      .CSR_AW (CSR_AW)
   ) u_wport_mux (
      .i_en       (reset),
      .i_seq_sel  (r_state != ST_IDLE),
      .i_drop_exu (w_accept),
      .i_exu_wen  (bus.io_exu_csr_is_w),
      .i_exu_addr (bus.io_exu_csr_addr),
      .i_exu_data (bus.io_exu_csr_data),
      .i_seq_wen  (w_seq_wen),
      .i_seq_addr (w_seq_addr),
      .i_seq_data (w_seq_data),
      .o_wen      (bus.io_csr_wen),
      .o_addr     (bus.io_csr_waddr),
      .o_data     (bus.io_csr_wdata)
   );

endmodule

// File: doc/csr_trap_sequencer.md
# csr_trap_sequencer

Multi-cycle trap-entry controller that sits between the system execution unit and the CSR file. It takes ecall/ebreak exceptions reported by the system execution unit and sequences the architectural trap entry through the CSR file's single write port: mepc, then mcause, then mstatus. It then redirects the fetch PC to mtvec. When no trap is in flight, it passes ordinary CSR-instruction writes through to the same write port, arbitrating between the two sources.

## Interface
Parameters:
- XLEN, 64, datapath/CSR width
- CSR_AW, 12, CSR address width

Ports:
- clock  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- io_valid  in  1  instruction in system stage is valid this cycle
- io_is_except  in  1  system unit reports ecall/ebreak (already qualified by valid upstream)
- io_exception  in  6  exception code (0xb ecall-M, 0x3 breakpoint)
- io_pc  in  XLEN  PC of the instruction in the system stage
- io_mstatus  in  XLEN  current mstatus
- io_mtvec  in  XLEN  current mtvec
- io_exu_csr_is_w  in  1  system unit requests a CSR write
- io_exu_csr_addr  in  CSR_AW  system unit write address
- io_exu_csr_data  in  XLEN  system unit write data
- io_ready  out  1  sequencer idle; a trap can be accepted
- io_busy  out  1  trap sequence in progress; upstream must stall
- io_flush  out  1  one-cycle pulse on trap acceptance; kill younger instructions
- io_csr_wen  out  1  CSR file write enable
- io_csr_waddr  out  CSR_AW  CSR file write address
- io_csr_wdata  out  XLEN  CSR file write data
- io_redirect_valid  out  1  one-cycle PC redirect pulse
- io_redirect_pc  out  XLEN  redirect target

## Operation
- FSM states: IDLE, W_MEPC, W_MCAUSE, W_MSTATUS, REDIRECT.
- IDLE:
  - io_ready=1.
  - A trap is accepted when io_valid & io_is_except.
  - On acceptance, latch io_pc, io_exception, io_mstatus and io_mtvec into snapshot registers, pulse io_flush, and go to W_MEPC.
- IDLE, no trap: the CSR port is a combinational pass-through of io_exu_csr_* (io_csr_wen = io_exu_csr_is_w).
- Simultaneous trap and EXU write in the acceptance cycle: the trap wins and the EXU write is dropped (io_csr_wen=0).
- W_MEPC: write addr 0x341, data = snapshot pc with bits [1:0] forced to 0. Next state W_MCAUSE.
- W_MCAUSE: write addr 0x342, data = zero-extended snapshot code (bit 63 = 0). Next state W_MSTATUS.
- W_MSTATUS: write addr 0x300. Data is the snapshot mstatus with:
  - MPIE[7] = old MIE[3]
  - MIE[3] = 0
  - MPP[12:11] = 2'b11
  - all other bits unchanged
  - Next state REDIRECT.
- REDIRECT:
  - io_redirect_valid=1.
  - io_redirect_pc = {snap_mtvec[63:2], 2'b00}. Direct mode only; the mode bits are ignored.
  - No CSR write. Next state IDLE.
- In every non-IDLE state, io_exu_csr_* is ignored; upstream is stalled by io_busy.
- io_busy = (state != IDLE). io_ready = (state == IDLE).
- mret/sret are not handled here: they are pure pass-through writes plus the system unit's own next-PC.
- Only the snapshot values are used after acceptance. Input changes during a sequence have no effect.

## Timing
- Reset (reset=0, asynchronous): state=IDLE and all snapshot registers are 0.
  - Reset output values: io_ready=1, io_busy=0, io_flush=0, io_csr_wen=0, io_redirect_valid=0, io_redirect_pc=0.
  - io_csr_waddr and io_csr_wdata equal the pass-through inputs, gated to 0 while reset is asserted.
- Trap accepted at cycle T. Write sequence: mepc at T+1, mcause at T+2, mstatus at T+3, redirect at T+4. The sequencer is back in IDLE at T+5.
- Trap-entry latency is 4 cycles from acceptance to redirect.
- Back-to-back traps: the next trap can be accepted at T+5 at the earliest. io_is_except during busy cycles is ignored.
- Pass-through has zero latency (combinational) in IDLE.
- Reset asserted mid-sequence: the sequence is aborted immediately, with no partial-write completion and no redirect.
- The trap-accept path has no combinational loop: io_flush depends only on state, io_valid and io_is_except.

## Structure
- Shared package (system/CSR definitions):
  - CSR address constants: MSTATUS=0x300, MTVEC=0x305, MEPC=0x341, MCAUSE=0x342.
  - mstatus bit positions: MIE=3, MPIE=7, MPP=12:11.
  - Exception codes: ECALL_M=0xb, BREAKPOINT=0x3.
  - FSM state encoding (3-bit enum).
- One sub-module, csr_wport_mux: selects between the pass-through source and the sequencer source for the CSR write port.
- The FSM, snapshot registers and the mstatus update logic stay in the top module.

## Test plan
- Reset with reset=0 mid-stream -> all outputs at reset values, io_ready=1; after release, pass-through works on the first cycle.
- Pass-through: idle, io_exu_csr_is_w=1, addr 0x305, data 0x8000_0000 -> same-cycle io_csr_wen=1, addr 0x305, data 0x8000_0000. No flush, no busy.
- ecall: io_pc=0x8000_0104, io_exception=0xb, io_mstatus=0x8, io_mtvec=0x8000_0001. Required response:
  - T: flush pulse.
  - T+1: write 0x341 = 0x8000_0104.
  - T+2: write 0x342 = 0xb.
  - T+3: write 0x300 = 0x1880.
  - T+4: redirect to 0x8000_0000.
  - io_busy high for T+1..T+4.
- ebreak with io_mstatus=0x0 -> mcause write 0x3, mstatus write 0x1800.
- Simultaneous trap and io_exu_csr_is_w=1 in IDLE -> EXU write suppressed; the trap sequence proceeds unchanged. A second ecall at T+2 is ignored, and a second ecall at T+5 is accepted.
- reset asserted at T+2 -> no mcause, mstatus or redirect observed; IDLE after release.
